multi_reg_bank: RTL and testbench

//  Parametrised bank of N general counter-registers; replaces the per-register LD/INR/CLR modules.
//  One shared load port (common-bus write); per-channel clear, increment and decrement.

---
 rtl/multi_reg_bank.sv | 129 ++++++++++++
 tb/tb_multi_reg_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_reg_bank.sv
// Parametrised bank of N counter-registers with a shared load port, per-channel
// clear/increment/decrement, sticky overflow flags and two combinational read ports.
module multi_reg_bank #(
    parameter int           W           = 16,
    parameter int           N           = 8,
    parameter int           SW          = 3,
    parameter int           AW          = 12,
    parameter logic [N-1:0] NARROW_MASK = {{(N-1){1'b0}}, 1'b1},
    parameter logic [W-1:0] RST_VEC     = 16'h012C,
    parameter bit           SAT         = 1'b0
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          LD,
    input  logic [SW-1:0] WSEL,
    input  logic [W-1:0]  Data_in,
    input  logic [N-1:0]  CLR,
    input  logic [N-1:0]  INR,
    input  logic [N-1:0]  DCR,
    input  logic [N-1:0]  OVF_CLR,
    input  logic [SW-1:0] RSEL_A,
    input  logic [SW-1:0] RSEL_B,
    output logic [W-1:0]  Data_a,
    output logic [W-1:0]  Data_b,
    output logic [N-1:0]  OVF,
    output logic [N-1:0]  ZERO
);

    // Largest value a channel can hold; narrow channels never carry bits above AW.
    function automatic logic [W-1:0] chan_max(input int idx);
        if (NARROW_MASK[idx]) begin
            return {W{1'b1}} >> (W - AW);
        end else begin
            return {W{1'b1}};
        end
    endfunction

    logic [W-1:0] val_r     [N];
    logic [W-1:0] val_nxt_s [N];
    logic [N-1:0] ovf_r;
    logic [N-1:0] ovf_nxt_s;
    logic [N-1:0] ld_hit_s;

    // Load-target decode; an out-of-range WSEL matches no channel.
    always_comb begin
        ld_hit_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (LD && (WSEL == SW'(i))) begin
                ld_hit_s[i] = 1'b1;
            end else begin
                ld_hit_s[i] = 1'b0;
            end
        end
    end

    // Per-channel next state: CLR > LD > INR/DCR > hold; overflow set beats OVF_CLR.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            val_nxt_s[i] = val_r[i];
            ovf_nxt_s[i] = ovf_r[i];
            if (CLR[i]) begin
                val_nxt_s[i] = {W{1'b0}};
                ovf_nxt_s[i] = 1'b0;
            end else if (ld_hit_s[i]) begin
                val_nxt_s[i] = Data_in & chan_max(i);
                ovf_nxt_s[i] = 1'b0;
            end else if (INR[i] && !DCR[i]) begin
                if (val_r[i] == chan_max(i)) begin
                    val_nxt_s[i] = SAT ? val_r[i] : {W{1'b0}};
                    ovf_nxt_s[i] = 1'b1;
                end else begin
                    val_nxt_s[i] = val_r[i] + W'(1);
                    ovf_nxt_s[i] = ovf_r[i] & ~OVF_CLR[i];
                end
            end else if (DCR[i] && !INR[i]) begin
                if (val_r[i] == {W{1'b0}}) begin
                    val_nxt_s[i] = SAT ? {W{1'b0}} : chan_max(i);
                    ovf_nxt_s[i] = 1'b1;
                end else begin
                    val_nxt_s[i] = val_r[i] - W'(1);
                    ovf_nxt_s[i] = ovf_r[i] & ~OVF_CLR[i];
                end
            end else begin
                ovf_nxt_s[i] = ovf_r[i] & ~OVF_CLR[i];
            end
        end
    end

    // State registers; channel 0 restarts at the program-counter start vector.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < N; i++) begin
                val_r[i] <= (i == 0) ? (RST_VEC & chan_max(0)) : {W{1'b0}};
            end
            ovf_r <= {N{1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                val_r[i] <= val_nxt_s[i];
            end
            ovf_r <= ovf_nxt_s;
        end
    end

    // Read ports show pre-edge state; out-of-range selects read as zero.
    always_comb begin
        Data_a = {W{1'b0}};
        Data_b = {W{1'b0}};
        if (32'(RSEL_A) < N) begin
            Data_a = val_r[RSEL_A];
        end else begin
            Data_a = {W{1'b0}};
        end
        if (32'(RSEL_B) < N) begin
            Data_b = val_r[RSEL_B];
        end else begin
            Data_b = {W{1'b0}};
        end
    end

    // Status flags.
    always_comb begin
        OVF  = ovf_r;
        ZERO = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            ZERO[i] = (val_r[i] == {W{1'b0}});
        end
    end

endmodule

// File: tb/tb_multi_reg_bank.sv
// Bench for multi_reg_bank: a wrapping and a saturating instance share stimulus and
// are checked every cycle against an arithmetic model, plus directed literal checks.
module tb_multi_reg_bank;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        LD;
    logic [2:0]  WSEL;
    logic [15:0] Data_in;
    logic [7:0]  CLR, INR, DCR, OVF_CLR;
    logic [2:0]  RSEL_A, RSEL_B;

    logic [15:0] da0, db0, da1, db1;
    logic [7:0]  ovf0, zero0, ovf1, zero1;

    int errors = 0;
    int checks = 0;
    bit model_valid = 1'b0;
    longint mv [2][8];
    bit     mo [2][8];

    always #5 CLK = ~CLK;

    multi_reg_bank #(.SAT(1'b0)) u_wrap (
        .CLK(CLK), .RST_N(RST_N), .LD(LD), .WSEL(WSEL), .Data_in(Data_in),
        .CLR(CLR), .INR(INR), .DCR(DCR), .OVF_CLR(OVF_CLR),
        .RSEL_A(RSEL_A), .RSEL_B(RSEL_B),
        .Data_a(da0), .Data_b(db0), .OVF(ovf0), .ZERO(zero0)
    );

    multi_reg_bank #(.SAT(1'b1)) u_sat (
        .CLK(CLK), .RST_N(RST_N), .LD(LD), .WSEL(WSEL), .Data_in(Data_in),
        .CLR(CLR), .INR(INR), .DCR(DCR), .OVF_CLR(OVF_CLR),
        .RSEL_A(RSEL_A), .RSEL_B(RSEL_B),
        .Data_a(da1), .Data_b(db1), .OVF(ovf1), .ZERO(zero1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: channel 0 is 12 bits wide, the rest 16; s==1 is the saturating build.
    always @(posedge CLK) begin
        int     wi;
        longint mx;
        bit     setev;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                wi    = (i == 0) ? 12 : 16;
                mx    = (longint'(1) << wi) - 1;
                setev = 1'b0;
                if (RST_N !== 1'b1) begin
                    mv[s][i] = (i == 0) ? (longint'('h12C) & mx) : 0;
                    mo[s][i] = 1'b0;
                end else if (CLR[i]) begin
                    mv[s][i] = 0;
                    mo[s][i] = 1'b0;
                end else if (LD && (int'(WSEL) == i)) begin
                    mv[s][i] = longint'(Data_in) & mx;
                    mo[s][i] = 1'b0;
                end else begin
                    if (INR[i] && !DCR[i]) begin
                        if (mv[s][i] == mx) begin
                            setev = 1'b1;
                            if (s == 0) mv[s][i] = 0;
                        end else begin
                            mv[s][i] = mv[s][i] + 1;
                        end
                    end else if (DCR[i] && !INR[i]) begin
                        if (mv[s][i] == 0) begin
                            setev = 1'b1;
                            if (s == 0) mv[s][i] = mx;
                        end else begin
                            mv[s][i] = mv[s][i] - 1;
                        end
                    end
                    if (setev) mo[s][i] = 1'b1;
                    else if (OVF_CLR[i]) mo[s][i] = 1'b0;
                end
            end
        end
        if (RST_N === 1'b0) model_valid = 1'b1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        logic [7:0] eo, ez;
        if (model_valid) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < 8; i++) begin
                    eo[i] = mo[s][i];
                    ez[i] = (mv[s][i] == 0);
                end
                check($sformatf("Data_a inst%0d sel%0d", s, RSEL_A), (s == 0) ? da0 : da1, 32'(mv[s][RSEL_A]));
                check($sformatf("Data_b inst%0d sel%0d", s, RSEL_B), (s == 0) ? db0 : db1, 32'(mv[s][RSEL_B]));
                check($sformatf("OVF inst%0d", s), (s == 0) ? ovf0 : ovf1, eo);
                check($sformatf("ZERO inst%0d", s), (s == 0) ? zero0 : zero1, ez);
            end
        end
    end

    task automatic idle();
        RST_N   = 1'b1;
        LD      = 1'b0;
        CLR     = 8'h00;
        INR     = 8'h00;
        DCR     = 8'h00;
        OVF_CLR = 8'h00;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
    endtask

    initial begin
        idle();
        WSEL = 3'd0; Data_in = 16'h0000; RSEL_A = 3'd0; RSEL_B = 3'd0;
        RST_N = 1'b0;
        tick();
        #1;
        check("reset_ch0_wrap", da0, 16'h012C);
        check("reset_ch0_sat", da1, 16'h012C);
        check("reset_ovf", ovf0, 8'h00);
        check("reset_zero", zero0, 8'hFE);

        LD = 1'b1; WSEL = 3'd3; Data_in = 16'hBEEF; INR = 8'h08;
        tick();
        RSEL_A = 3'd3; #1;
        check("ld_over_inr", da0, 16'hBEEF);

        LD = 1'b1; WSEL = 3'd3; Data_in = 16'hBEEF; CLR = 8'h08;
        tick();
        #1;
        check("clr_over_ld", da0, 16'h0000);
        check("clr_zero_flag", zero0[3], 1'b1);

        LD = 1'b1; WSEL = 3'd0; Data_in = 16'hFFFF;
        tick();
        RSEL_A = 3'd0; #1;
        check("narrow_load", da0, 16'h0FFF);

        INR = 8'h01;
        tick();
        #1;
        check("narrow_wrap", da0, 16'h0000);
        check("narrow_wrap_ovf", ovf0[0], 1'b1);
        check("narrow_sat_hold", da1, 16'h0FFF);

        OVF_CLR = 8'h01;
        tick();
        #1;
        check("ovf_clr", ovf0[0], 1'b0);

        RSEL_B = 3'd2; DCR = 8'h04;
        tick();
        #1;
        check("sat_dcr_hold", db1, 16'h0000);
        check("sat_dcr_ovf", ovf1[2], 1'b1);
        check("wrap_dcr", db0, 16'hFFFF);

        LD = 1'b1; WSEL = 3'd2; Data_in = 16'hFFFF;
        tick();
        INR = 8'h04; OVF_CLR = 8'h04;
        tick();
        #1;
        check("sat_inr_hold", db1, 16'hFFFF);
        check("set_beats_ovf_clr", ovf1[2], 1'b1);
        check("wrap_inr", db0, 16'h0000);

        LD = 1'b1; WSEL = 3'd5; Data_in = 16'h0007;
        tick();
        INR = 8'h20; DCR = 8'h20;
        tick();
        RSEL_A = 3'd5; #1;
        check("inr_dcr_hold", da0, 16'h0007);
        check("inr_dcr_ovf", ovf0[5], 1'b0);

        INR = 8'hFF;
        tick();
        RSEL_B = 3'd4; #1;
        check("inr_all_ch5", da0, 16'h0008);
        check("inr_all_ch4", db0, 16'h0001);

        RSEL_A = 3'd1;
        for (int c = 0; c < 10; c++) begin
            INR = 8'h02;
            if (c == 5) RST_N = 1'b0;
            tick();
        end
        #1;
        check("midreset_count", da0, 16'h0004);
        RSEL_B = 3'd0; #1;
        check("midreset_ch0", db0, 16'h012C);

        for (int c = 0; c < 80; c++) begin
            LD      = ($urandom_range(0, 5) == 0);
            WSEL    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       Data_in = 16'hFFFF;
                1:       Data_in = 16'h0FFF;
                2:       Data_in = 16'h0000;
                default: Data_in = 16'($urandom);
            endcase
            CLR     = 8'($urandom & $urandom & $urandom);
            INR     = 8'($urandom);
            DCR     = 8'($urandom);
            OVF_CLR = 8'($urandom & $urandom);
            RSEL_A  = 3'($urandom_range(0, 7));
            RSEL_B  = 3'($urandom_range(0, 7));
            RST_N   = ($urandom_range(0, 29) != 0);
            @(posedge CLK);
            #1;
        end
        idle();
        tick();
        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
